// File: rtl/elastic_pipe_reg_if.sv
// Handshake bundle for elastic_pipe_reg. The upstream valid/data/side, downstream ready,
// and the registered outputs travel together.
// master: the producer/consumer side that drives the pipe.
// slave:  the pipe itself.
interface elastic_pipe_reg_if #(
  parameter int Word_Length = 8,
  parameter int Side_Width  = 4,
  parameter int Depth       = 2
);
  localparam int OccWidth = $clog2(Depth + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [Word_Length-1:0] Data_Input;
  logic [Side_Width-1:0]  Side_Input;
  logic                   out_valid;
  logic                   out_ready;
  logic [Word_Length-1:0] Data_Output;
  logic [Side_Width-1:0]  Side_Output;
  logic [OccWidth-1:0]    Occupancy;

  modport master (
    output in_valid, Data_Input, Side_Input, out_ready,
    input  in_ready, out_valid, Data_Output, Side_Output, Occupancy
  );

  modport slave (
    input  in_valid, Data_Input, Side_Input, out_ready,
    output in_ready, out_valid, Data_Output, Side_Output, Occupancy
  );
endinterface

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: Depth-stage valid/ready pipeline register carrying data plus sideband.
// Empty stages absorb words even while the output is stalled (bubble collapsing), and
// sys_reset flushes every stage synchronously.
// Optional build macro ELASTIC_PIPE_STATS_EN adds a saturating 16-bit Stall_Count output.
module elastic_pipe_reg #(
  parameter int Word_Length = 8,
  parameter int Side_Width  = 4,
  parameter int Depth       = 2
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic              sys_reset,  // synchronous flush, active-high
  elastic_pipe_reg_if.slave pipe
`ifdef ELASTIC_PIPE_STATS_EN
  ,
  output logic [15:0]       Stall_Count
`endif
);
  localparam int OccWidth = $clog2(Depth + 1);

  logic [Depth-1:0]       v_all;
  logic [Depth-1:0]       rdy;
  logic [Word_Length-1:0] d_all [Depth];
  logic [Side_Width-1:0]  s_all [Depth];
  logic                   in_xfer;
  logic                   out_xfer;
  logic [OccWidth-1:0]    occ_q;
  logic [OccWidth-1:0]    occ_d;

  // Stage gi can take a word when any stage from gi to the output is empty, or the output
  // drains this cycle. The closed form avoids a bit-to-bit combinational chain.
  for (genvar gi = 0; gi < Depth; gi++) begin : g_rdy
    assign rdy[gi] = ~(&v_all[Depth-1:gi]) | pipe.out_ready;
  end

  assign pipe.in_ready = rdy[0] & ~sys_reset;
  assign in_xfer       = pipe.in_valid & pipe.in_ready;
  assign out_xfer      = v_all[Depth-1] & pipe.out_ready;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_stage
    logic                   v_q;
    logic                   v_d;
    logic [Word_Length-1:0] d_q;
    logic [Word_Length-1:0] d_d;
    logic [Side_Width-1:0]  s_q;
    logic [Side_Width-1:0]  s_d;
    logic                   prev_v;
    logic [Word_Length-1:0] prev_d;
    logic [Side_Width-1:0]  prev_s;

    if (gi == 0) begin : g_head
      assign prev_v = in_xfer;
      assign prev_d = pipe.Data_Input;
      assign prev_s = pipe.Side_Input;
    end else begin : g_body
      assign prev_v = v_all[gi-1];
      assign prev_d = d_all[gi-1];
      assign prev_s = s_all[gi-1];
    end

    // Next state: flush wins; otherwise advance when free, moving payload only with a valid word.
    always_comb begin
      v_d = v_q;
      d_d = d_q;
      s_d = s_q;
      if (sys_reset) begin
        v_d = 1'b0;
        d_d = '0;
        s_d = '0;
      end else if (rdy[gi]) begin
        v_d = prev_v;
        if (prev_v) begin
          d_d = prev_d;
          s_d = prev_s;
        end
      end
    end

    // Stage storage, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_q <= 1'b0;
        d_q <= '0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
        s_q <= s_d;
      end
    end

    assign v_all[gi] = v_q;
    assign d_all[gi] = d_q;
    assign s_all[gi] = s_q;
  end

  // Occupancy tracks the number of valid stages: it rises on in only and falls on out only.
  always_comb begin
    occ_d = occ_q;
    if (sys_reset) begin
      occ_d = '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   occ_d = occ_q + OccWidth'(1);
        2'b01:   occ_d = occ_q - OccWidth'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign pipe.out_valid   = v_all[Depth-1];
  assign pipe.Data_Output = d_all[Depth-1];
  assign pipe.Side_Output = s_all[Depth-1];
  assign pipe.Occupancy   = occ_q;

`ifdef ELASTIC_PIPE_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  // Count cycles where the output holds a word nobody takes; saturate rather than wrap.
  always_comb begin
    stall_d = stall_q;
    if (sys_reset) begin
      stall_d = '0;
    end else if (v_all[Depth-1] && !pipe.out_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign Stall_Count = stall_q;
`endif
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: a Depth=2 and a Depth=3 instance share clock and resets.
// Inputs change on the falling edge and outputs are sampled there, away from the rising edge.
module tb_elastic_pipe_reg;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sys_reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  elastic_pipe_reg_if #(.Word_Length(8), .Side_Width(4), .Depth(2)) if2 ();
  elastic_pipe_reg_if #(.Word_Length(8), .Side_Width(4), .Depth(3)) if3 ();

`ifdef ELASTIC_PIPE_STATS_EN
  logic [15:0] stall2;
  logic [15:0] stall3;
`endif

  elastic_pipe_reg #(.Word_Length(8), .Side_Width(4), .Depth(2)) u2 (
    .clk(clk), .reset(reset), .sys_reset(sys_reset), .pipe(if2.slave)
`ifdef ELASTIC_PIPE_STATS_EN
    , .Stall_Count(stall2)
`endif
  );

  elastic_pipe_reg #(.Word_Length(8), .Side_Width(4), .Depth(3)) u3 (
    .clk(clk), .reset(reset), .sys_reset(sys_reset), .pipe(if3.slave)
`ifdef ELASTIC_PIPE_STATS_EN
    , .Stall_Count(stall3)
`endif
  );

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive2(input logic v, input logic [7:0] d, input logic [3:0] s);
    if2.in_valid = v; if2.Data_Input = d; if2.Side_Input = s;
  endtask

  task automatic drive3(input logic v, input logic [7:0] d, input logic [3:0] s);
    if3.in_valid = v; if3.Data_Input = d; if3.Side_Input = s;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", if2.out_valid); end
    checks++; if (if2.Occupancy !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", if2.Occupancy); end
    checks++; if (if2.Data_Output !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", if2.Data_Output); end
    checks++; if (if2.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", if2.in_ready); end
    checks++; if (if3.Occupancy !== 2'd0) begin failures++; $display("FAIL rst_occ3 got=%0d exp=0", if3.Occupancy); end
    $display("reset: out_valid=%0b occ=%0d in_ready=%0b", if2.out_valid, if2.Occupancy, if2.in_ready);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Depth=2, free-flowing output: three back-to-back words, two cycles of latency.
  task automatic test_stream();
    logic [7:0] din [5];
    logic [3:0] sin [5];
    logic       exp_v [5];
    logic [7:0] exp_d [5];
    logic [3:0] exp_s [5];
    logic [1:0] exp_o [5];
    din   = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
    sin   = '{4'h1, 4'h2, 4'h3, 4'h0, 4'h0};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h33};
    exp_s = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3};
    exp_o = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
    if2.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive2(k < 3, din[k], sin[k]);
      #1;
      if (k < 3) begin
        checks++; if (if2.in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready k=%0d got=%0b exp=1", k, if2.in_ready); end
      end
      tick();
      checks++; if (if2.out_valid !== exp_v[k]) begin failures++; $display("FAIL stream_valid k=%0d got=%0b exp=%0b", k, if2.out_valid, exp_v[k]); end
      checks++; if (if2.Data_Output !== exp_d[k]) begin failures++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, if2.Data_Output, exp_d[k]); end
      checks++; if (if2.Side_Output !== exp_s[k]) begin failures++; $display("FAIL stream_side k=%0d got=%h exp=%h", k, if2.Side_Output, exp_s[k]); end
      checks++; if (if2.Occupancy !== exp_o[k]) begin failures++; $display("FAIL stream_occ k=%0d got=%0d exp=%0d", k, if2.Occupancy, exp_o[k]); end
      $display("stream k=%0d out_valid=%0b data=%h side=%h occ=%0d", k, if2.out_valid, if2.Data_Output, if2.Side_Output, if2.Occupancy);
    end
  endtask

  // Depth=2, stalled output: fill, observe full, then drain in order.
  task automatic test_fill();
    if2.out_ready = 1'b0;
    drive2(1'b1, 8'hA1, 4'hA);
    tick();
    checks++; if (if2.Occupancy !== 2'd1) begin failures++; $display("FAIL fill_occ1 got=%0d exp=1", if2.Occupancy); end
    drive2(1'b1, 8'hA2, 4'hB);
    #1;
    checks++; if (if2.in_ready !== 1'b1) begin failures++; $display("FAIL fill_in_ready2 got=%0b exp=1", if2.in_ready); end
    tick();
    checks++; if (if2.Occupancy !== 2'd2) begin failures++; $display("FAIL fill_occ2 got=%0d exp=2", if2.Occupancy); end
    checks++; if (if2.Data_Output !== 8'hA1) begin failures++; $display("FAIL fill_head got=%h exp=a1", if2.Data_Output); end
    drive2(1'b1, 8'hA3, 4'hC);
    #1;
    checks++; if (if2.in_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%0b exp=0", if2.in_ready); end
    tick();
    checks++; if (if2.Data_Output !== 8'hA1 || if2.out_valid !== 1'b1) begin failures++; $display("FAIL fill_hold got=%h/%0b exp=a1/1", if2.Data_Output, if2.out_valid); end
    checks++; if (if2.Occupancy !== 2'd2) begin failures++; $display("FAIL fill_occ_hold got=%0d exp=2", if2.Occupancy); end
    $display("fill: held data=%h occ=%0d", if2.Data_Output, if2.Occupancy);
    if2.out_ready = 1'b1;
    #1;
    checks++; if (if2.in_ready !== 1'b1) begin failures++; $display("FAIL fill_pass_ready got=%0b exp=1", if2.in_ready); end
    drive2(1'b0, 8'h00, 4'h0);
    tick();
    checks++; if (if2.Data_Output !== 8'hA2 || if2.Side_Output !== 4'hB || if2.out_valid !== 1'b1) begin failures++; $display("FAIL fill_drain2 got=%h/%h/%0b exp=a2/b/1", if2.Data_Output, if2.Side_Output, if2.out_valid); end
    checks++; if (if2.Occupancy !== 2'd1) begin failures++; $display("FAIL fill_occ_drain got=%0d exp=1", if2.Occupancy); end
    $display("fill: drain data=%h occ=%0d", if2.Data_Output, if2.Occupancy);
    tick();
    checks++; if (if2.out_valid !== 1'b0 || if2.Occupancy !== 2'd0) begin failures++; $display("FAIL fill_empty got=%0b/%0d exp=0/0", if2.out_valid, if2.Occupancy); end
  endtask

  // Depth=3: the single word reaches the output, then the empty stages absorb two more.
  task automatic test_bubble();
    if3.out_ready = 1'b0;
    drive3(1'b1, 8'hB1, 4'h1);
    tick();
    drive3(1'b0, 8'h00, 4'h0);
    tick();
    tick();
    checks++; if (if3.out_valid !== 1'b1 || if3.Data_Output !== 8'hB1) begin failures++; $display("FAIL bub_head got=%0b/%h exp=1/b1", if3.out_valid, if3.Data_Output); end
    checks++; if (if3.Occupancy !== 2'd1) begin failures++; $display("FAIL bub_occ1 got=%0d exp=1", if3.Occupancy); end
    drive3(1'b1, 8'hB2, 4'h2);
    #1;
    checks++; if (if3.in_ready !== 1'b1) begin failures++; $display("FAIL bub_ready2 got=%0b exp=1", if3.in_ready); end
    tick();
    checks++; if (if3.Occupancy !== 2'd2) begin failures++; $display("FAIL bub_occ2 got=%0d exp=2", if3.Occupancy); end
    drive3(1'b1, 8'hB3, 4'h3);
    #1;
    checks++; if (if3.in_ready !== 1'b1) begin failures++; $display("FAIL bub_ready3 got=%0b exp=1", if3.in_ready); end
    tick();
    checks++; if (if3.Occupancy !== 2'd3) begin failures++; $display("FAIL bub_occ3 got=%0d exp=3", if3.Occupancy); end
    drive3(1'b1, 8'hB4, 4'h4);
    #1;
    checks++; if (if3.in_ready !== 1'b0) begin failures++; $display("FAIL bub_full got=%0b exp=0", if3.in_ready); end
    checks++; if (if3.Data_Output !== 8'hB1) begin failures++; $display("FAIL bub_hold got=%h exp=b1", if3.Data_Output); end
    $display("bubble: occ=%0d in_ready=%0b data=%h", if3.Occupancy, if3.in_ready, if3.Data_Output);
    drive3(1'b0, 8'h00, 4'h0);
    if3.out_ready = 1'b1;
    tick();
    checks++; if (if3.Data_Output !== 8'hB2 || if3.Side_Output !== 4'h2) begin failures++; $display("FAIL bub_out2 got=%h/%h exp=b2/2", if3.Data_Output, if3.Side_Output); end
    tick();
    checks++; if (if3.Data_Output !== 8'hB3 || if3.out_valid !== 1'b1) begin failures++; $display("FAIL bub_out3 got=%h/%0b exp=b3/1", if3.Data_Output, if3.out_valid); end
    tick();
    checks++; if (if3.out_valid !== 1'b0 || if3.Occupancy !== 2'd0) begin failures++; $display("FAIL bub_empty got=%0b/%0d exp=0/0", if3.out_valid, if3.Occupancy); end
    $display("bubble: drained occ=%0d", if3.Occupancy);
  endtask

  // Synchronous flush with two words held, then a fresh word passes through.
  task automatic test_flush();
    if2.out_ready = 1'b0;
    drive2(1'b1, 8'hC1, 4'h1);
    tick();
    drive2(1'b1, 8'hC2, 4'h2);
    tick();
    checks++; if (if2.Occupancy !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", if2.Occupancy); end
    sys_reset = 1'b1;
    drive2(1'b1, 8'hEE, 4'hE);
    #1;
    checks++; if (if2.in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", if2.in_ready); end
    tick();
    sys_reset = 1'b0;
    drive2(1'b0, 8'h00, 4'h0);
    checks++; if (if2.out_valid !== 1'b0 || if2.Occupancy !== 2'd0) begin failures++; $display("FAIL flush_state got=%0b/%0d exp=0/0", if2.out_valid, if2.Occupancy); end
    checks++; if (if2.Data_Output !== 8'h00 || if2.Side_Output !== 4'h0) begin failures++; $display("FAIL flush_clear got=%h/%h exp=00/0", if2.Data_Output, if2.Side_Output); end
    $display("flush: out_valid=%0b occ=%0d", if2.out_valid, if2.Occupancy);
    if2.out_ready = 1'b1;
    drive2(1'b1, 8'h5A, 4'h5);
    tick();
    drive2(1'b0, 8'h00, 4'h0);
    checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL flush_lat1 got=%0b exp=0", if2.out_valid); end
    tick();
    checks++; if (if2.out_valid !== 1'b1 || if2.Data_Output !== 8'h5A) begin failures++; $display("FAIL flush_5a got=%0b/%h exp=1/5a", if2.out_valid, if2.Data_Output); end
    $display("flush: post data=%h", if2.Data_Output);
    tick();
  endtask

  // Asynchronous reset between clock edges while full, then a clean restart.
  task automatic test_async_reset();
    if2.out_ready = 1'b0;
    drive2(1'b1, 8'h61, 4'h6);
    tick();
    drive2(1'b1, 8'h62, 4'h7);
    tick();
    drive2(1'b0, 8'h00, 4'h0);
    checks++; if (if2.out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0b exp=1", if2.out_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (if2.out_valid !== 1'b0 || if2.Occupancy !== 2'd0) begin failures++; $display("FAIL ar_state got=%0b/%0d exp=0/0", if2.out_valid, if2.Occupancy); end
    checks++; if (if2.Data_Output !== 8'h00 || if2.Side_Output !== 4'h0) begin failures++; $display("FAIL ar_data got=%h/%h exp=00/0", if2.Data_Output, if2.Side_Output); end
    $display("async reset: out_valid=%0b data=%h occ=%0d", if2.out_valid, if2.Data_Output, if2.Occupancy);
    @(negedge clk);
    reset = 1'b1;
    if2.out_ready = 1'b1;
    drive2(1'b1, 8'h77, 4'h7);
    tick();
    drive2(1'b0, 8'h00, 4'h0);
    checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL ar_lat got=%0b exp=0", if2.out_valid); end
    tick();
    checks++; if (if2.out_valid !== 1'b1 || if2.Data_Output !== 8'h77) begin failures++; $display("FAIL ar_resume got=%0b/%h exp=1/77", if2.out_valid, if2.Data_Output); end
    $display("async reset: resumed data=%h", if2.Data_Output);
    tick();
  endtask

`ifdef ELASTIC_PIPE_STATS_EN
  // Ten stalled cycles are counted, and the flush clears the counter.
  task automatic test_stats();
    checks++; if (stall2 !== 16'd0) begin failures++; $display("FAIL stat_start got=%0d exp=0", stall2); end
    if2.out_ready = 1'b0;
    drive2(1'b1, 8'hD1, 4'h1);
    tick();
    drive2(1'b0, 8'h00, 4'h0);
    tick();
    checks++; if (if2.out_valid !== 1'b1 || stall2 !== 16'd0) begin failures++; $display("FAIL stat_arm got=%0b/%0d exp=1/0", if2.out_valid, stall2); end
    repeat (10) tick();
    checks++; if (stall2 !== 16'd10) begin failures++; $display("FAIL stat_count got=%0d exp=10", stall2); end
    $display("stats: stall_count=%0d", stall2);
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    checks++; if (stall2 !== 16'd0) begin failures++; $display("FAIL stat_clear got=%0d exp=0", stall2); end
    $display("stats: after flush stall_count=%0d", stall2);
  endtask
`endif

  initial begin
    drive2(1'b0, 8'h00, 4'h0);
    drive3(1'b0, 8'h00, 4'h0);
    if2.out_ready = 1'b1;
    if3.out_ready = 1'b1;
    test_reset();
    test_stream();
    test_fill();
    test_bubble();
    test_flush();
    test_async_reset();
`ifdef ELASTIC_PIPE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
